// File: rtl/dipsw_pkg.sv
// rtl/dipsw_pkg.sv - shared constants and FSM encoding for the DIP-switch filter
package dipsw_pkg;

    localparam int DIPSW_WIDTH    = 32;
    localparam int DIPSW_TICK_DIV = 50000;
    localparam int DIPSW_STABLE_N = 4;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } dipsw_state_t;

endpackage

// File: rtl/dipsw_filter_bit.sv
// rtl/dipsw_filter_bit.sv - per-bit debounce counter and stable level
module dipsw_filter_bit #(
    parameter int STABLE_N = 4
) (
    input  logic clk,
    input  logic rst_I,
    input  logic tick,
    input  logic run,
    input  logic sample,
    output logic level,
    output logic toggle
);

    localparam int CW = (STABLE_N > 1) ? $clog2(STABLE_N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_N - 1);

    logic [CW-1:0] cnt;
    logic          stable;

    // Asserted in the cycle whose closing edge flips the stable level.
    assign toggle = tick && run && (sample != stable) && (cnt == CNT_LAST);
    assign level  = stable;

    always_ff @(posedge clk or negedge rst_I) begin
        if (!rst_I) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (tick) begin
            if (!run) begin
                stable <= sample;
                cnt    <= '0;
            end else if (sample == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sample;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dipsw_filter.sv
// rtl/dipsw_filter.sv - DIP-switch synchroniser, debouncer and change interrupt
module dipsw_filter
    import dipsw_pkg::*;
#(
    parameter int WIDTH    = DIPSW_WIDTH,
    parameter int TICK_DIV = DIPSW_TICK_DIV,
    parameter int STABLE_N = DIPSW_STABLE_N
) (
    input  logic             clk,
    input  logic             rst_I,
    input  logic [WIDTH-1:0] dipsw_raw,
    input  logic [WIDTH-1:0] chg_clr,
    input  logic             chg_we,
    output logic [WIDTH-1:0] dipsw_out,
    output logic [WIDTH-1:0] chg_mask,
    output logic             irq,
    output logic             tick
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRE_PEN  = PW'(TICK_DIV - 2);

    logic [WIDTH-1:0] sync1, sync2;
    logic [PW-1:0]    pre;
    dipsw_state_t     state;
    logic [WIDTH-1:0] toggle;
    logic [WIDTH-1:0] chg_mask_next;

    always_ff @(posedge clk or negedge rst_I) begin
        if (!rst_I) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= dipsw_raw;
            sync2 <= sync1;
        end
    end

    // tick is decoded one count early so it is high while pre == TICK_DIV-1.
    always_ff @(posedge clk or negedge rst_I) begin
        if (!rst_I) begin
            pre  <= '0;
            tick <= 1'b0;
        end else begin
            pre  <= (pre == PRE_LAST) ? '0 : pre + 1'b1;
            tick <= (pre == PRE_PEN);
        end
    end

    always_ff @(posedge clk or negedge rst_I) begin
        if (!rst_I) begin
            state <= ST_INIT;
        end else begin
            case (state)
                ST_INIT: if (tick) state <= ST_RUN;
                default: state <= ST_RUN;
            endcase
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        dipsw_filter_bit #(
            .STABLE_N(STABLE_N)
        ) u_bit (
            .clk   (clk),
            .rst_I (rst_I),
            .tick  (tick),
            .run   (state == ST_RUN),
            .sample(sync2[i]),
            .level (dipsw_out[i]),
            .toggle(toggle[i])
        );
    end

    // Set is applied after clear so a coincident toggle keeps the bit.
    always_comb begin
        chg_mask_next = chg_mask;
        if (chg_we) chg_mask_next = chg_mask_next & ~chg_clr;
        chg_mask_next = chg_mask_next | toggle;
    end

    always_ff @(posedge clk or negedge rst_I) begin
        if (!rst_I) begin
            chg_mask <= '0;
            irq      <= 1'b0;
        end else begin
            chg_mask <= chg_mask_next;
            irq      <= |chg_mask_next;
        end
    end

endmodule

// File: tb/tb_dipsw_filter.sv
// tb/tb_dipsw_filter.sv - scoreboard bench for dipsw_filter
module tb_dipsw_filter;

    localparam int W  = 32;
    localparam int TD = 4;
    localparam int SN = 3;

    logic         clk = 1'b0;
    logic         rst_I;
    logic [W-1:0] dipsw_raw;
    logic [W-1:0] chg_clr;
    logic         chg_we;
    logic [W-1:0] dipsw_out;
    logic [W-1:0] chg_mask;
    logic         irq;
    logic         tick;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string        tag;
        logic [W-1:0] out;
        logic [W-1:0] mask;
        logic         irq;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    dipsw_filter #(
        .WIDTH(W), .TICK_DIV(TD), .STABLE_N(SN)
    ) dut (
        .clk      (clk),
        .rst_I    (rst_I),
        .dipsw_raw(dipsw_raw),
        .chg_clr  (chg_clr),
        .chg_we   (chg_we),
        .dipsw_out(dipsw_out),
        .chg_mask (chg_mask),
        .irq      (irq),
        .tick     (tick)
    );

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input logic [W-1:0] o, input logic [W-1:0] m, input logic i);
        exp_t e;
        e.tag = tag; e.out = o; e.mask = m; e.irq = i;
        sb.push_back(e);
    endtask

    task automatic pop_cmp();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_empty", W'(0), W'(1));
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_out"},  dipsw_out, e.out);
            chk({e.tag, "_mask"}, chg_mask,  e.mask);
            chk({e.tag, "_irq"},  W'(irq),   W'(e.irq));
        end
    endtask

    // Stop at the negedge where tick is seen high; bounded.
    task automatic wait_tick_hi();
        int n = 0;
        while (tick !== 1'b1 && n < 3 * TD) begin
            @(negedge clk);
            n++;
        end
        if (tick !== 1'b1) chk("tick_timeout", W'(tick), W'(1));
    endtask

    // Return at the negedge just after n processing edges.
    task automatic tick_wait(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            wait_tick_hi();
            @(negedge clk);
        end
    endtask

    task automatic clr_pulse(input logic [W-1:0] m, input logic we);
        chg_clr = m;
        chg_we  = we;
        @(negedge clk);
        chg_we  = 1'b0;
        chg_clr = '0;
    endtask

    initial begin
        int cyc;
        rst_I     = 1'b0;
        dipsw_raw = 32'hA5A5_0F0F;
        chg_clr   = '0;
        chg_we    = 1'b0;
        repeat (3) @(negedge clk);
        push("rst", '0, '0, 1'b0);
        pop_cmp();
        chk("rst_tick", W'(tick), W'(0));

        // 1: INIT load on first tick
        rst_I = 1'b1;
        cyc = 0;
        while (tick !== 1'b1 && cyc < 3 * TD) begin
            @(negedge clk);
            cyc++;
        end
        chk("first_tick", W'(cyc), W'(TD - 1));
        push("init", 32'hA5A5_0F0F, '0, 1'b0);
        @(negedge clk);
        pop_cmp();
        chk("tick_one_cycle", W'(tick), W'(0));

        // settle to zero, then clear every change bit
        dipsw_raw = '0;
        push("to_zero", '0, 32'hA5A5_0F0F, 1'b1);
        tick_wait(SN);
        pop_cmp();
        push("clr_all", '0, '0, 1'b0);
        clr_pulse('1, 1'b1);
        pop_cmp();

        // 2: clean rise on bit 0
        dipsw_raw = 32'h1;
        push("b0_hold", '0, '0, 1'b0);
        tick_wait(SN - 1);
        pop_cmp();
        push("b0_accept", 32'h1, 32'h1, 1'b1);
        tick_wait(1);
        pop_cmp();

        // 3: bit 5 bounces 2 high / 1 low / 2 high, then a third high tick
        dipsw_raw = 32'h21;
        tick_wait(2);
        dipsw_raw = 32'h01;
        tick_wait(1);
        dipsw_raw = 32'h21;
        push("b5_bounce", 32'h1, 32'h1, 1'b1);
        tick_wait(2);
        pop_cmp();
        push("b5_accept", 32'h21, 32'h21, 1'b1);
        tick_wait(1);
        pop_cmp();

        // 4: clear behaviour
        push("we_low_ignored", 32'h21, 32'h21, 1'b1);
        clr_pulse('1, 1'b0);
        pop_cmp();
        push("clr_b0", 32'h21, 32'h20, 1'b1);
        clr_pulse(32'h1, 1'b1);
        pop_cmp();
        push("clr_b5", 32'h21, 32'h0, 1'b0);
        clr_pulse(32'h20, 1'b1);
        pop_cmp();

        // 5: accept and clear of bit 3 in the same cycle
        tick_wait(1);
        dipsw_raw = 32'h29;
        tick_wait(SN - 1);
        wait_tick_hi();
        push("set_wins", 32'h29, 32'h8, 1'b1);
        clr_pulse(32'h8, 1'b1);
        pop_cmp();

        // 6: async reset mid-count
        clr_pulse(32'h8, 1'b1);
        tick_wait(1);
        dipsw_raw = 32'h28;
        push("b0_fall", 32'h28, 32'h1, 1'b1);
        tick_wait(SN);
        pop_cmp();
        dipsw_raw = 32'hA8;
        push("b7_pending", 32'h28, 32'h1, 1'b1);
        tick_wait(SN - 1);
        pop_cmp();
        #2 rst_I = 1'b0;
        #1;
        push("async_rst", '0, '0, 1'b0);
        pop_cmp();
        chk("async_rst_tick", W'(tick), W'(0));
        dipsw_raw = 32'h1234_5678;
        repeat (2) @(negedge clk);
        rst_I = 1'b1;
        push("reinit", 32'h1234_5678, '0, 1'b0);
        tick_wait(1);
        pop_cmp();
        push("reinit_hold", 32'h1234_5678, '0, 1'b0);
        tick_wait(SN);
        pop_cmp();

        chk("sb_drained", W'(sb.size()), W'(0));
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dipsw_filter.md
Name: dipsw_filter

Overview:
- Synchronises and debounces the raw 32 DIP-switch pins before they reach the switch device (device 3) behind the bridge.
- Provides stable switch levels, a sticky per-bit change mask and a level interrupt, so software can react to switch edits without polling.
- Sits between the top-level dipsw pins and the switch device's dipsw input, in the clk1x domain.

Parameters:
- WIDTH, 32: number of switch bits.
- TICK_DIV, 50000: clocks per sample tick (1 ms at 50 MHz); legal range is 2 or more.
- STABLE_N, 4: consecutive differing samples required to accept a new level; legal range is 1 or more.

Ports:
- clk, input, 1: system clock (clk1x).
- rst_I, input, 1: reset, asynchronous, active-low.
- dipsw_raw, input, WIDTH: asynchronous switch pins.
- chg_clr, input, WIDTH: write-1-to-clear mask for chg_mask; sampled only when chg_we=1.
- chg_we, input, 1: single-cycle clear strobe.
- dipsw_out, output, WIDTH: debounced switch levels; feeds the switch device.
- chg_mask, output, WIDTH: sticky bits, set when the corresponding dipsw_out bit toggles.
- irq, output, 1: registered OR of chg_mask; intended for a DevIRQ line.
- tick, output, 1: one-cycle sample strobe, exposed for the testbench.

Behaviour:
- Reset (rst_I=0, asynchronous): all of the following are cleared to 0 immediately, including when reset lands mid-count: sync flops, prescaler, per-bit counters, dipsw_out, chg_mask, irq, tick. FSM goes to INIT.
- Synchroniser: 2-flop per bit, sync2 <= sync1 <= dipsw_raw.
- Prescaler: counts 0..TICK_DIV-1 and wraps to 0. tick=1 for exactly the cycle in which the count equals TICK_DIV-1 (registered). The first tick after reset release therefore occurs TICK_DIV cycles later.
- FSM states:
  - INIT: on the first tick, dipsw_out <= sync2 directly. chg_mask is not set and per-bit counters are cleared. Go to RUN.
  - RUN: per-bit filtering on every tick, as below. There is no other exit; only reset returns the FSM to INIT.
- Per-bit filter (RUN, on tick):
  - sync2[i]==dipsw_out[i]: cnt[i] <= 0.
  - sync2[i]!=dipsw_out[i] and cnt[i]<STABLE_N-1: cnt[i] <= cnt[i]+1.
  - sync2[i]!=dipsw_out[i] and cnt[i]==STABLE_N-1: dipsw_out[i] <= sync2[i], cnt[i] <= 0, set chg_mask[i].
  - No tick: cnt and dipsw_out hold.
- Counter width: $clog2(STABLE_N) with a minimum of 1. With STABLE_N=1 a difference is accepted on the first tick.
- Bounce rule: any matching sample resets the count, so a glitch shorter than STABLE_N ticks never reaches dipsw_out.
- Latency: a clean edge reaches dipsw_out between 2+(STABLE_N-1)*TICK_DIV+1 and 2+STABLE_N*TICK_DIV clocks after the pin changes. The exact value depends on prescaler phase.
- chg_mask rules:
  - When chg_we=1, clear bits where chg_clr=1; bits where chg_clr=0 are untouched.
  - A set and a clear of the same bit in the same cycle: set wins, bit stays 1.
  - chg_we=0: chg_clr is ignored.
- irq <= |chg_mask_next, one register stage. irq falls the cycle after the last set bit is cleared. irq is a level, not a pulse.
- All outputs are registered; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package dipsw_pkg:
  - default constants DIPSW_WIDTH=32, DIPSW_TICK_DIV=50000, DIPSW_STABLE_N=4.
  - FSM state encoding (ST_INIT=1'b0, ST_RUN=1'b1).
- Sub-module dipsw_filter_bit, instantiated WIDTH times by generate:
  - inputs: clk, rst_I, tick, run, sample.
  - holds cnt and the stable bit.
  - outputs: level and a one-cycle toggle pulse.
- The top holds the synchroniser, prescaler, FSM, chg_mask and irq.

Test Plan (bench uses TICK_DIV=4, STABLE_N=3, WIDTH=32):
1. Reset with dipsw_raw=32'hA5A5_0F0F, then release. First tick at cycle 4 -> dipsw_out=32'hA5A5_0F0F, chg_mask=0, irq=0.
2. From dipsw_out=0, set bit 0 high and hold -> dipsw_out[0]=1 on the 3rd tick after sync. chg_mask=32'h1 and irq=1 one cycle later.
3. Bit 5 bounces, high for 2 ticks, low for 1, high for 2 -> dipsw_out[5] stays 0 and chg_mask[5]=0. After a 3rd consecutive high tick, dipsw_out[5]=1.
4. chg_mask=32'h21; pulse chg_we with chg_clr=32'h1 -> chg_mask=32'h20 and irq stays 1. Then clear 32'h20 -> chg_mask=0 and irq=0 on the following cycle.
5. Bit 3's accepting tick coincides with chg_we=1, chg_clr=32'h8 -> chg_mask[3]=1 (set wins), irq=1.
6. Assert rst_I=0 mid-count (bit 7 at cnt=2, chg_mask=32'h1) -> all outputs 0 immediately. After release, INIT reloads dipsw_out from the pins with no chg bits set.
